// File: rtl/riscv_imm_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
// The entry struct is sized for the widest datapath; narrower builds use the low bits.
package riscv_imm_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0]         inst;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
        logic [XLEN_MAX-1:0] target;
        logic                illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate extraction and pc+imm target for one instruction.
// Compressed immediates are decoded only when IMMGEN_RVC_EN is defined.
module imm_decode_comb
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_target,
    output logic            o_illegal
);

    logic [6:0]      w_opcode;
    logic            w_sign;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    imm_fmt_e        w_fmt;
    logic            w_hasTarget;
    logic            w_illegal;

    assign w_opcode = i_inst[6:0];
    assign w_sign   = i_inst[31];

    always_comb begin
        w_fmt       = IMM_NONE;
        w_imm32     = '0;
        w_hasTarget = 1'b0;
        w_illegal   = 1'b0;
        if (i_inst[1:0] == 2'b11) begin
            case (w_opcode)
                OPCODE_LOAD, OPCODE_LOAD_FP, OPCODE_OP_IMM, OPCODE_JALR: begin
                    w_fmt   = IMM_I;
                    w_imm32 = {{20{w_sign}}, i_inst[31:20]};
                end
                OPCODE_STORE, OPCODE_STORE_FP: begin
                    w_fmt   = IMM_S;
                    w_imm32 = {{20{w_sign}}, i_inst[31:25], i_inst[11:7]};
                end
                OPCODE_BRANCH: begin
                    w_fmt       = IMM_B;
                    w_imm32     = {{19{w_sign}}, w_sign, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                    w_hasTarget = 1'b1;
                end
                OPCODE_LUI: begin
                    w_fmt   = IMM_U;
                    w_imm32 = {i_inst[31:12], 12'b0};
                end
                OPCODE_AUIPC: begin
                    w_fmt       = IMM_U;
                    w_imm32     = {i_inst[31:12], 12'b0};
                    w_hasTarget = 1'b1;
                end
                OPCODE_JAL: begin
                    w_fmt       = IMM_J;
                    w_imm32     = {{11{w_sign}}, w_sign, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
                    w_hasTarget = 1'b1;
                end
                default: ;
            endcase
        end else begin
`ifdef IMMGEN_RVC_EN
            // Case key is {quadrant, funct3}; C.ADDI16SP shares C.LUI's funct3 and is rejected.
            case ({i_inst[1:0], i_inst[15:13]})
                5'b01_000, 5'b01_010: begin
                    w_fmt   = IMM_I;
                    w_imm32 = {{26{i_inst[12]}}, i_inst[12], i_inst[6:2]};
                end
                5'b01_011: begin
                    if (i_inst[11:7] != 5'd2) begin
                        w_fmt   = IMM_U;
                        w_imm32 = {{14{i_inst[12]}}, i_inst[12], i_inst[6:2], 12'b0};
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                5'b01_001, 5'b01_101: begin
                    w_fmt       = IMM_J;
                    w_imm32     = {{20{i_inst[12]}}, i_inst[12], i_inst[8], i_inst[10:9], i_inst[6],
                                   i_inst[7], i_inst[2], i_inst[11], i_inst[5:3], 1'b0};
                    w_hasTarget = 1'b1;
                end
                5'b01_110, 5'b01_111: begin
                    w_fmt       = IMM_B;
                    w_imm32     = {{23{i_inst[12]}}, i_inst[12], i_inst[6:5], i_inst[2],
                                   i_inst[11:10], i_inst[4:3], 1'b0};
                    w_hasTarget = 1'b1;
                end
                5'b00_010: begin
                    w_fmt   = IMM_I;
                    w_imm32 = {25'b0, i_inst[5], i_inst[12:10], i_inst[6], 2'b0};
                end
                5'b00_110: begin
                    w_fmt   = IMM_S;
                    w_imm32 = {25'b0, i_inst[5], i_inst[12:10], i_inst[6], 2'b0};
                end
                default: w_illegal = 1'b1;
            endcase
`else
            w_illegal = 1'b1;
`endif
        end
    end

    assign w_imm     = XLEN'($signed(w_imm32));
    assign o_imm     = w_imm;
    assign o_fmt     = w_fmt;
    assign o_target  = w_hasTarget ? (i_pc + w_imm) : '0;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/immediate_decode_stage.sv
// Registered immediate-decode stage with a main entry and a skid entry (2-deep FIFO).
// Optional compressed-immediate decode is enabled by defining IMMGEN_RVC_EN.
module immediate_decode_stage
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam logic [XLEN_MAX-1:0] HI_MASK = ~({XLEN_MAX{1'b1}} >> (XLEN_MAX - XLEN));

    imm_entry_t      r_main;
    imm_entry_t      r_skid;
    logic            r_mainValid;
    logic            r_skidValid;

    imm_entry_t      w_decoded;
    logic [XLEN-1:0] w_decImm;
    logic [2:0]      w_decFmt;
    logic [XLEN-1:0] w_decTarget;
    logic            w_decIllegal;
    logic            w_accept;
    logic            w_mainFree;
    logic            w_unused_hi;

    imm_decode_comb #(
        .XLEN(XLEN)
    ) u_decode (
        .i_inst    (in_inst),
        .i_pc      (in_pc),
        .o_imm     (w_decImm),
        .o_fmt     (w_decFmt),
        .o_target  (w_decTarget),
        .o_illegal (w_decIllegal)
    );

    always_comb begin
        w_decoded         = '0;
        w_decoded.inst    = in_inst;
        w_decoded.pc      = XLEN_MAX'(in_pc);
        w_decoded.imm     = XLEN_MAX'(w_decImm);
        w_decoded.fmt     = imm_fmt_e'(w_decFmt);
        w_decoded.target  = XLEN_MAX'(w_decTarget);
        w_decoded.illegal = w_decIllegal;
    end

    assign in_ready   = !r_skidValid && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_mainFree = !r_mainValid || out_ready;

    // When the main entry drains, the skid entry moves up and the skid takes any new input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_main      <= '0;
            r_skid      <= '0;
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_mainFree) begin
            if (r_skidValid) begin
                r_main      <= r_skid;
                r_mainValid <= 1'b1;
                r_skidValid <= w_accept;
                if (w_accept) begin
                    r_skid <= w_decoded;
                end
            end else begin
                r_mainValid <= w_accept;
                if (w_accept) begin
                    r_main <= w_decoded;
                end
            end
        end else if (w_accept) begin
            r_skid      <= w_decoded;
            r_skidValid <= 1'b1;
        end
    end

    assign out_valid   = r_mainValid;
    assign out_inst    = r_main.inst;
    assign out_pc      = r_main.pc[XLEN-1:0];
    assign out_imm     = r_main.imm[XLEN-1:0];
    assign out_fmt     = r_main.fmt;
    assign out_target  = r_main.target[XLEN-1:0];
    assign out_illegal = r_main.illegal;

    assign w_unused_hi = |((r_main.pc | r_main.imm | r_main.target) & HI_MASK);

endmodule
